// File: rtl/issue_queue.sv
// Collapsing in-order-age issue queue: buffers renamed ops, snoops write-back wakeups, issues oldest fully-ready op.
// Latency: dispatch with ready sources at edge N issues at edge N+1; a wakeup at edge N makes the entry issuable at edge N+1.
// Backpressure: DISP_READY drops when full, frozen or flushing; no full-bypass, so a full queue refuses dispatch even when it issues.
module issue_queue #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 137,
  parameter int TAG_WIDTH  = 6,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FREEZE,
  input  logic                  FLUSH,
  input  logic                  DISP_VALID,
  input  logic [DATA_WIDTH-1:0] DISP_DATA,
  input  logic [TAG_WIDTH-1:0]  DISP_SRC1,
  input  logic [TAG_WIDTH-1:0]  DISP_SRC2,
  input  logic                  DISP_SRC1_RDY,
  input  logic                  DISP_SRC2_RDY,
  output logic                  DISP_READY,
  input  logic                  WAKE_FLAG,
  input  logic [TAG_WIDTH-1:0]  WAKE_INDEX,
  output logic                  ISSUE_VALID,
  output logic [DATA_WIDTH-1:0] ISSUE_DATA,
  output logic [CNT_WIDTH-1:0]  COUNT
);

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] dat;
    logic [TAG_WIDTH-1:0]  src1;
    logic                  rdy1;
    logic [TAG_WIDTH-1:0]  src2;
    logic                  rdy2;
  } entry_t;

  entry_t                entry_q [DEPTH];
  entry_t                entry_d [DEPTH];
  // One extra slot so the shift-down path can read index i+1 for the top entry.
  entry_t                woken   [DEPTH+1];
  entry_t                new_entry;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  issue_valid_q, issue_valid_d;
  logic [DATA_WIDTH-1:0] issue_data_q, issue_data_d;
  logic [DEPTH-1:0]      cand;
  logic                  has_cand;
  int                    sel_idx;
  logic [DATA_WIDTH-1:0] sel_dat;
  int                    ins_idx;
  logic                  disp_rdy;
  logic                  disp_accept;
  logic                  do_issue;

  assign disp_rdy    = !FREEZE && !FLUSH && (count_q < CNT_WIDTH'(DEPTH));
  assign DISP_READY  = disp_rdy;
  assign ISSUE_VALID = issue_valid_q;
  assign ISSUE_DATA  = issue_data_q;
  assign COUNT       = count_q;

  // Apply the write-back wakeup to every stored entry; candidates use the pre-wakeup ready bits.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = entry_q[i];
      if (entry_q[i].vld && WAKE_FLAG) begin
        if (entry_q[i].src1 == WAKE_INDEX) woken[i].rdy1 = 1'b1;
        if (entry_q[i].src2 == WAKE_INDEX) woken[i].rdy2 = 1'b1;
      end
      cand[i] = entry_q[i].vld && entry_q[i].rdy1 && entry_q[i].rdy2;
    end
    woken[DEPTH] = '0;
  end

  // Oldest-first select: scanning downward leaves the lowest ready index as the winner.
  always_comb begin
    has_cand = 1'b0;
    sel_idx  = 0;
    sel_dat  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        has_cand = 1'b1;
        sel_idx  = i;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == sel_idx) sel_dat = entry_q[i].dat;
    end
  end

  // Build the incoming entry, folding in a wakeup that lands on the same edge as dispatch.
  always_comb begin
    new_entry      = '0;
    new_entry.vld  = 1'b1;
    new_entry.dat  = DISP_DATA;
    new_entry.src1 = DISP_SRC1;
    new_entry.src2 = DISP_SRC2;
    new_entry.rdy1 = DISP_SRC1_RDY || (WAKE_FLAG && (DISP_SRC1 == WAKE_INDEX));
    new_entry.rdy2 = DISP_SRC2_RDY || (WAKE_FLAG && (DISP_SRC2 == WAKE_INDEX));
  end

  // Next-state: collapse above the issued slot, append at the tail, flush overrides everything.
  always_comb begin
    disp_accept   = DISP_VALID && disp_rdy;
    do_issue      = !FREEZE && !FLUSH && has_cand;
    ins_idx       = int'(count_q) - (do_issue ? 1 : 0);
    count_d       = count_q;
    issue_valid_d = issue_valid_q;
    issue_data_d  = issue_data_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = woken[i];
      if (do_issue && (i >= sel_idx)) entry_d[i] = woken[i+1];
      if (disp_accept && (i == ins_idx)) entry_d[i] = new_entry;
    end
    if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i]      = entry_q[i];
        entry_d[i].vld  = 1'b0;
        entry_d[i].rdy1 = 1'b0;
        entry_d[i].rdy2 = 1'b0;
      end
      count_d       = '0;
      issue_valid_d = 1'b0;
    end else if (!FREEZE) begin
      count_d       = count_q + CNT_WIDTH'(disp_accept) - CNT_WIDTH'(do_issue);
      issue_valid_d = has_cand;
      if (has_cand) issue_data_d = sel_dat;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_data_q  <= issue_data_d;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: ordering, wakeup timing, full, freeze, flush and collapse cases.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises the full-queue refusal and freeze/flush dispatch blocking.
module tb_issue_queue;
  localparam int DW = 137;
  localparam int TW = 6;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          FREEZE, FLUSH, DISP_VALID;
  logic [DW-1:0] DISP_DATA;
  logic [TW-1:0] DISP_SRC1, DISP_SRC2;
  logic          DISP_SRC1_RDY, DISP_SRC2_RDY;
  logic          DISP_READY;
  logic          WAKE_FLAG;
  logic [TW-1:0] WAKE_INDEX;
  logic          ISSUE_VALID;
  logic [DW-1:0] ISSUE_DATA;
  logic [CW-1:0] COUNT;

  int tests_run = 0;
  int fails     = 0;

  issue_queue #(.DEPTH(8), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH),
    .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA),
    .DISP_SRC1(DISP_SRC1), .DISP_SRC2(DISP_SRC2),
    .DISP_SRC1_RDY(DISP_SRC1_RDY), .DISP_SRC2_RDY(DISP_SRC2_RDY),
    .DISP_READY(DISP_READY), .WAKE_FLAG(WAKE_FLAG), .WAKE_INDEX(WAKE_INDEX),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_DATA(ISSUE_DATA), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic disp(input logic [DW-1:0] d, input logic [TW-1:0] s1, input logic r1,
                      input logic [TW-1:0] s2, input logic r2);
    DISP_VALID = 1'b1; DISP_DATA = d;
    DISP_SRC1 = s1; DISP_SRC1_RDY = r1; DISP_SRC2 = s2; DISP_SRC2_RDY = r2;
  endtask

  task automatic idle();
    DISP_VALID = 1'b0; WAKE_FLAG = 1'b0; FREEZE = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic wake(input logic [TW-1:0] t);
    WAKE_FLAG = 1'b1; WAKE_INDEX = t;
  endtask

  task automatic test_reset();
    RESET = 1'b0; idle();
    DISP_DATA = '0; DISP_SRC1 = '0; DISP_SRC2 = '0; DISP_SRC1_RDY = 1'b1; DISP_SRC2_RDY = 1'b1;
    WAKE_INDEX = '0;
    #12;
    tests_run++; if (ISSUE_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ISSUE_VALID); end
    tests_run++; if (ISSUE_DATA !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", ISSUE_DATA); end
    tests_run++; if (COUNT !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    RESET = 1'b1;
    #1;
    tests_run++; if (DISP_READY !== 1'b1) begin fails++; $display("FAIL reset_disp_ready: got %b want 1", DISP_READY); end
    @(negedge CLK);
  endtask

  task automatic test_basic_order();
    logic [DW-1:0] exp [3];
    exp[0] = DW'(32'hA); exp[1] = DW'(32'hB); exp[2] = DW'(32'hC);
    disp(exp[0], 6'd1, 1'b1, 6'd2, 1'b1); step();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) disp(exp[k+1], 6'd1, 1'b1, 6'd2, 1'b1); else idle();
      step();
      tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== exp[k]) begin fails++;
        $display("FAIL basic_issue%0d: got v=%b d=%h want v=1 d=%h", k, ISSUE_VALID, ISSUE_DATA, exp[k]); end
    end
    tests_run++; if (COUNT !== 4'd0) begin fails++; $display("FAIL basic_count: got %0d want 0", COUNT); end
    step();
    tests_run++; if (ISSUE_VALID !== 1'b0) begin fails++; $display("FAIL basic_idle_valid: got %b want 0", ISSUE_VALID); end
  endtask

  task automatic test_wakeup();
    disp(DW'(32'h100), 6'd5, 1'b0, 6'd0, 1'b1); step();
    disp(DW'(32'h200), 6'd1, 1'b1, 6'd2, 1'b1); step();
    idle(); step();
    tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== DW'(32'h200)) begin fails++;
      $display("FAIL wake_y_first: got v=%b d=%h want v=1 d=200", ISSUE_VALID, ISSUE_DATA); end
    wake(6'd5); step();
    tests_run++; if (ISSUE_VALID !== 1'b0 || COUNT !== 4'd1) begin fails++;
      $display("FAIL wake_not_same_edge: got v=%b cnt=%0d want v=0 cnt=1", ISSUE_VALID, COUNT); end
    idle(); step();
    tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== DW'(32'h100) || COUNT !== 4'd0) begin fails++;
      $display("FAIL wake_x_next_edge: got v=%b d=%h cnt=%0d want v=1 d=100 cnt=0", ISSUE_VALID, ISSUE_DATA, COUNT); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      disp(DW'(32'h10 + k), 6'd20, 1'b0, 6'd0, 1'b1); step();
    end
    disp(DW'(32'hFF), 6'd1, 1'b1, 6'd2, 1'b1);
    #1;
    tests_run++; if (DISP_READY !== 1'b0 || COUNT !== 4'd8) begin fails++;
      $display("FAIL full_refuse: got rdy=%b cnt=%0d want rdy=0 cnt=8", DISP_READY, COUNT); end
    step();
    tests_run++; if (COUNT !== 4'd8 || ISSUE_VALID !== 1'b0) begin fails++;
      $display("FAIL full_ninth_ignored: got cnt=%0d v=%b want cnt=8 v=0", COUNT, ISSUE_VALID); end
    idle(); wake(6'd20); step();
    idle();
    for (int k = 0; k < 8; k++) begin
      step();
      tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== DW'(32'h10 + k)) begin fails++;
        $display("FAIL full_drain%0d: got v=%b d=%h want v=1 d=%h", k, ISSUE_VALID, ISSUE_DATA, DW'(32'h10 + k)); end
    end
    step();
    tests_run++; if (ISSUE_VALID !== 1'b0 || COUNT !== 4'd0 || DISP_READY !== 1'b1) begin fails++;
      $display("FAIL full_empty: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", ISSUE_VALID, COUNT, DISP_READY); end
  endtask

  task automatic test_freeze();
    disp(DW'(32'h300), 6'd7, 1'b0, 6'd0, 1'b1); step();
    disp(DW'(32'h333), 6'd1, 1'b1, 6'd2, 1'b1); step();
    idle(); step();
    tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== DW'(32'h333)) begin fails++;
      $display("FAIL freeze_pre: got v=%b d=%h want v=1 d=333", ISSUE_VALID, ISSUE_DATA); end
    FREEZE = 1'b1; wake(6'd7);
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== DW'(32'h333) || COUNT !== 4'd1) begin fails++;
        $display("FAIL freeze_hold%0d: got v=%b d=%h cnt=%0d want v=1 d=333 cnt=1", k, ISSUE_VALID, ISSUE_DATA, COUNT); end
    end
    idle(); step();
    tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== DW'(32'h300) || COUNT !== 4'd0) begin fails++;
      $display("FAIL freeze_release: got v=%b d=%h cnt=%0d want v=1 d=300 cnt=0", ISSUE_VALID, ISSUE_DATA, COUNT); end
  endtask

  task automatic test_same_cycle_wake_and_flush();
    disp(DW'(32'h400), 6'd9, 1'b0, 6'd0, 1'b1); wake(6'd9); step();
    idle(); step();
    tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== DW'(32'h400)) begin fails++;
      $display("FAIL disp_wake_issue: got v=%b d=%h want v=1 d=400", ISSUE_VALID, ISSUE_DATA); end
    for (int k = 0; k < 3; k++) begin
      disp(DW'(32'h410 + k), 6'd30, 1'b0, 6'd0, 1'b1); step();
    end
    disp(DW'(32'h4FF), 6'd1, 1'b1, 6'd2, 1'b1); step();
    tests_run++; if (COUNT !== 4'd4) begin fails++; $display("FAIL flush_pre_count: got %0d want 4", COUNT); end
    FLUSH = 1'b1; disp(DW'(32'h777), 6'd1, 1'b1, 6'd2, 1'b1);
    #1;
    tests_run++; if (DISP_READY !== 1'b0) begin fails++; $display("FAIL flush_disp_ready: got %b want 0", DISP_READY); end
    step();
    tests_run++; if (COUNT !== 4'd0 || ISSUE_VALID !== 1'b0 || ISSUE_DATA !== DW'(32'h400)) begin fails++;
      $display("FAIL flush_clear: got cnt=%0d v=%b d=%h want cnt=0 v=0 d=400", COUNT, ISSUE_VALID, ISSUE_DATA); end
    idle(); wake(6'd30); step();
    idle(); step();
    tests_run++; if (ISSUE_VALID !== 1'b0 || COUNT !== 4'd0) begin fails++;
      $display("FAIL flush_no_ghost: got v=%b cnt=%0d want v=0 cnt=0", ISSUE_VALID, COUNT); end
  endtask

  task automatic test_middle_issue();
    logic [DW-1:0] exp [5];
    for (int k = 0; k < 5; k++) begin
      if (k == 2) disp(DW'(32'h52), 6'd42, 1'b0, 6'd42, 1'b0);
      else        disp(DW'(32'h50 + k), 6'd50, 1'b0, 6'd50, 1'b0);
      step();
    end
    idle(); wake(6'd42); step();
    tests_run++; if (ISSUE_VALID !== 1'b0 || COUNT !== 4'd5) begin fails++;
      $display("FAIL mid_pre: got v=%b cnt=%0d want v=0 cnt=5", ISSUE_VALID, COUNT); end
    idle(); disp(DW'(32'h55), 6'd50, 1'b0, 6'd0, 1'b1); step();
    tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== DW'(32'h52) || COUNT !== 4'd5) begin fails++;
      $display("FAIL mid_issue: got v=%b d=%h cnt=%0d want v=1 d=52 cnt=5", ISSUE_VALID, ISSUE_DATA, COUNT); end
    idle(); wake(6'd50); step();
    idle();
    exp[0] = DW'(32'h50); exp[1] = DW'(32'h51); exp[2] = DW'(32'h53); exp[3] = DW'(32'h54); exp[4] = DW'(32'h55);
    for (int k = 0; k < 5; k++) begin
      step();
      tests_run++; if (ISSUE_VALID !== 1'b1 || ISSUE_DATA !== exp[k]) begin fails++;
        $display("FAIL mid_order%0d: got v=%b d=%h want v=1 d=%h", k, ISSUE_VALID, ISSUE_DATA, exp[k]); end
    end
    tests_run++; if (COUNT !== 4'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", COUNT); end
  endtask

  task automatic test_async_reset();
    disp(DW'(32'h600), 6'd60, 1'b0, 6'd0, 1'b1); step();
    disp(DW'(32'h601), 6'd60, 1'b0, 6'd0, 1'b1); step();
    idle();
    tests_run++; if (COUNT !== 4'd2) begin fails++; $display("FAIL areset_pre: got %0d want 2", COUNT); end
    #2 RESET = 1'b0;
    #1;
    tests_run++; if (COUNT !== 4'd0 || ISSUE_VALID !== 1'b0 || ISSUE_DATA !== '0) begin fails++;
      $display("FAIL areset_now: got cnt=%0d v=%b d=%h want cnt=0 v=0 d=0", COUNT, ISSUE_VALID, ISSUE_DATA); end
    @(negedge CLK); RESET = 1'b1;
    wake(6'd60); step();
    idle(); step();
    tests_run++; if (ISSUE_VALID !== 1'b0 || COUNT !== 4'd0) begin fails++;
      $display("FAIL areset_cleared: got v=%b cnt=%0d want v=0 cnt=0", ISSUE_VALID, COUNT); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_wakeup();
    test_full();
    test_freeze();
    test_same_cycle_wake_and_flush();
    test_middle_issue();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
